wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the peripheral interconnect master port (periph_ic io_m_0) between N bus masters, e.g. the core bridge, a debug/DMA master and test BFMs.
- Grants one master at a time and holds the grant for the whole CYC burst.
- Each master ACK/ERR is returned only to the owner.
- A watchdog terminates stalled transfers with ERR, so a missing slave cannot hang the SoC.

Parameters:
- N_MASTERS, 4: number of requesting masters (2..8).
- ADDR_WIDTH, 32: Wishbone address width.
- DATA_WIDTH, 32: Wishbone data width; SEL width is DATA_WIDTH/8.
- TIMEOUT, 255: cycles with STB asserted and no ACK/ERR before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_ADR  in  N_MASTERS*ADDR_WIDTH  master addresses, master i at slice i
- m_DAT_W  in  N_MASTERS*DATA_WIDTH  master write data
- m_SEL  in  N_MASTERS*DATA_WIDTH/8  master byte selects
- m_CYC  in  N_MASTERS  cycle/request per master
- m_STB  in  N_MASTERS  strobe per master
- m_WE  in  N_MASTERS  write enable per master
- m_DAT_R  out  DATA_WIDTH  read data, broadcast to all masters
- m_ACK  out  N_MASTERS  acknowledge, owner only
- m_ERR  out  N_MASTERS  error, owner only
- s_ADR  out  ADDR_WIDTH  to interconnect
- s_DAT_W  out  DATA_WIDTH
- s_SEL  out  DATA_WIDTH/8
- s_CYC  out  1
- s_STB  out  1
- s_WE  out  1
- s_DAT_R  in  DATA_WIDTH
- s_ACK  in  1
- s_ERR  in  1
- gnt_o  out  N_MASTERS  one-hot current owner, for monitors

Behaviour:
- Clock and reset: single clock, clk_i. Reset is synchronous and active-high: rst_i is sampled on the rising edge of clk_i.
- Reset values: state=IDLE, gnt=0, prio pointer=0, wdog=0. All outputs 0: s_CYC, s_STB, s_WE, s_ADR, s_DAT_W, s_SEL, m_ACK, m_ERR and gnt_o.
- Reset mid-transfer: state returns to IDLE the next edge and no ACK/ERR is forwarded, even if s_ACK is high.
- State IDLE:
  - s_CYC=0.
  - If any m_CYC is high, the registered one-hot gnt is loaded with the first requester at or after the prio pointer (wrapping modulo N_MASTERS), and the next state is GRANT.
  - Arbitration latency is 1 cycle: the slave sees s_CYC no earlier than the cycle after the request.
- State GRANT:
  - Slave outputs are a combinational mux of the granted master's signals.
  - s_CYC = m_CYC[g]. s_STB = m_STB[g].
  - m_ACK[g] = s_ACK and m_ERR[g] = s_ERR, gated by gnt. Non-owners always read 0.
  - The grant is held while m_CYC[g]=1; requests from other masters are ignored, with no preemption.
  - When m_CYC[g]=0: next state is IDLE and prio pointer = g+1 mod N_MASTERS.
- Watchdog:
  - In GRANT, wdog increments each cycle with s_STB=1 and s_ACK=s_ERR=0.
  - wdog clears on ACK, ERR, or when STB=0.
  - When wdog reaches TIMEOUT, the next state is ABORT.
  - wdog saturates and never wraps; its width is clog2(TIMEOUT+1).
- State ABORT (exactly 1 cycle):
  - s_CYC=s_STB=0.
  - m_ERR[g]=1 for this cycle only.
  - Next state is IDLE, prio pointer = g+1, wdog=0.
  - A late s_ACK during ABORT is dropped.
- Simultaneous events:
  - s_ACK and wdog==TIMEOUT in the same cycle: the ACK wins, it is forwarded, and wdog clears.
  - The owner drops CYC on the same cycle another master raises CYC: the transition goes IDLE then the next grant, giving a minimum 1-cycle bus gap.
- Single requester: re-granted on every IDLE pass, so there is no starvation.
- All requests active: grants rotate 0,1,2,3,0,...
- gnt_o equals the gnt register; it is 0 in IDLE and holds its value through ABORT.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {IDLE, GRANT, ABORT};
  - function clog2;
  - a localparam helper for SEL width.
- Sub-module wb_rr_prio_enc: combinational rotating priority encoder.
  - Inputs: req[N], ptr[clog2 N].
  - Outputs: one-hot gnt, valid.
- The top level holds the FSM, the watchdog, the mux and the ACK/ERR demux.

Test Plan:
- Reset mid-transfer: m0 is mid-write with wdog=10 and rst_i is pulsed for 1 cycle. Next cycle all outputs are 0 and the state is IDLE. After release, the m0 CYC still held is re-granted 1 cycle later.
- Single master write: m1 writes ADR=0x1000_0004, DAT_W=0xDEADBEEF, SEL=0xF, and the slave ACKs 2 cycles later. s_ADR/s_DAT_W match, only m_ACK[1] pulses, gnt_o=0b0010, and the state is IDLE 1 cycle after CYC drops.
- Fairness: all four masters hold CYC for one 1-beat transfer each, repeated. Grant order is 0,1,2,3,0, with exactly 1 idle cycle between grants.
- No preemption: m2 runs a 4-beat burst while m0 requests. m0 is not granted until m2 drops CYC; no ACK reaches m0 during the burst.
- Timeout: TIMEOUT=8 and the slave never ACKs m3. m_ERR[3] pulses exactly 1 cycle, the 9th cycle after STB, with s_CYC=0 that cycle. m0 is granted next if requesting.
- ACK/timeout race: the slave ACKs on the cycle wdog==TIMEOUT. The ACK is forwarded, no ERR is raised, and the bus stays in GRANT.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Holds the FSM state encoding plus width helpers used by the top and encoder.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ABORT
    } state_e;

    localparam int BYTE_BITS = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int sel_width(input int dataWidth);
        return dataWidth / BYTE_BITS;
    endfunction

endpackage

// File: rtl/wb_rr_prio_enc.sv
// Rotating priority encoder: picks the first requester at or after ptr_i,
// wrapping modulo N, and reports it one-hot.
module wb_rr_prio_enc
    import wb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req_i,
    input  logic [clog2(N)-1:0] ptr_i,
    output logic [N-1:0]        gnt_o,
    output logic                valid_o
);

    logic found;

    // Scan offsets 0..N-1 from the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner per CYC burst, ACK/ERR routed to the
// owner only, and a watchdog that aborts stalled strobes with ERR.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]             m_ADR,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]             m_DAT_W,
    input  logic [N_MASTERS*sel_width(DATA_WIDTH)-1:0]  m_SEL,
    input  logic [N_MASTERS-1:0]                        m_CYC,
    input  logic [N_MASTERS-1:0]                        m_STB,
    input  logic [N_MASTERS-1:0]                        m_WE,
    output logic [DATA_WIDTH-1:0]                       m_DAT_R,
    output logic [N_MASTERS-1:0]                        m_ACK,
    output logic [N_MASTERS-1:0]                        m_ERR,
    output logic [ADDR_WIDTH-1:0]                       s_ADR,
    output logic [DATA_WIDTH-1:0]                       s_DAT_W,
    output logic [sel_width(DATA_WIDTH)-1:0]            s_SEL,
    output logic                                        s_CYC,
    output logic                                        s_STB,
    output logic                                        s_WE,
    input  logic [DATA_WIDTH-1:0]                       s_DAT_R,
    input  logic                                        s_ACK,
    input  logic                                        s_ERR,
    output logic [N_MASTERS-1:0]                        gnt_o
);

    localparam int SW = sel_width(DATA_WIDTH);
    localparam int PW = clog2(N_MASTERS);
    localparam int WW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [WW-1:0]          wdog_q, wdog_d;

    logic [N_MASTERS-1:0]   encGnt;
    logic                   encValid;
    logic [ADDR_WIDTH-1:0]  muxAdr;
    logic [DATA_WIDTH-1:0]  muxDat;
    logic [SW-1:0]          muxSel;
    logic                   ownCyc, ownStb, ownWe;
    logic [PW-1:0]          gIdx, nextPtr;
    logic                   inGrant;

    wb_rr_prio_enc #(.N(N_MASTERS)) uPrioEnc (
        .req_i   (m_CYC),
        .ptr_i   (ptr_q),
        .gnt_o   (encGnt),
        .valid_o (encValid)
    );

    // AND-OR mux gated by the one-hot grant; an empty grant yields all zeros.
    always_comb begin
        muxAdr = '0;
        muxDat = '0;
        muxSel = '0;
        ownCyc = 1'b0;
        ownStb = 1'b0;
        ownWe  = 1'b0;
        gIdx   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_q[i]) begin
                muxAdr = muxAdr | m_ADR[i*ADDR_WIDTH +: ADDR_WIDTH];
                muxDat = muxDat | m_DAT_W[i*DATA_WIDTH +: DATA_WIDTH];
                muxSel = muxSel | m_SEL[i*SW +: SW];
                ownCyc = ownCyc | m_CYC[i];
                ownStb = ownStb | m_STB[i];
                ownWe  = ownWe | m_WE[i];
                gIdx   = gIdx | PW'(i);
            end
        end
    end

    assign nextPtr = (gIdx == PW'(N_MASTERS - 1)) ? '0 : gIdx + PW'(1);
    assign inGrant = (state_q == GRANT);

    assign s_ADR   = muxAdr;
    assign s_DAT_W = muxDat;
    assign s_SEL   = muxSel;
    assign s_CYC   = inGrant & ownCyc;
    assign s_STB   = inGrant & ownStb;
    assign s_WE    = inGrant & ownWe;
    assign m_DAT_R = s_DAT_R;
    assign gnt_o   = gnt_q;

    // Responses are suppressed during reset so a late slave ACK cannot leak out.
    assign m_ACK = (!rst_i && inGrant && s_ACK) ? gnt_q : '0;
    assign m_ERR = (!rst_i && ((inGrant && s_ERR) || state_q == ABORT)) ? gnt_q : '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (encValid) begin
                    gnt_d   = encGnt;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!ownCyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = nextPtr;
                    wdog_d  = '0;
                end else if (s_ACK || s_ERR || !ownStb) begin
                    wdog_d = '0;
                end else if (wdog_q == WW'(TIMEOUT)) begin
                    // A zero TIMEOUT parks the counter at 0 and never aborts.
                    if (TIMEOUT != 0) begin
                        state_d = ABORT;
                        wdog_d  = '0;
                    end
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            ABORT: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = nextPtr;
                wdog_d  = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, directed corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N*AW-1:0] mAdr;
    logic [N*DW-1:0] mDatW;
    logic [N*4-1:0]  mSel;
    logic [N-1:0]    mCyc, mStb, mWe;
    logic [DW-1:0]   mDatR;
    logic [N-1:0]    mAck, mErr, gnt;
    logic [AW-1:0]   sAdr;
    logic [DW-1:0]   sDatW, sDatR;
    logic [3:0]      sSel;
    logic            sCyc, sStb, sWe, sAck, sErr;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, whether the abort beat is pending,
    // where the round-robin search starts, and how long the strobe has stalled.
    int refOwner = -1;
    bit refAbort = 1'b0;
    int refPtr   = 0;
    int refWdog  = 0;

    typedef struct {
        logic [3:0] cyc;
        logic       ack;
        logic       err;
        logic [3:0] expGnt;
        logic       expSCyc;
        logic [3:0] expAck;
        logic [3:0] expErr;
    } vec_t;

    vec_t vecs[17];

    wb_rr_arbiter #(
        .N_MASTERS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .m_ADR  (mAdr),
        .m_DAT_W(mDatW),
        .m_SEL  (mSel),
        .m_CYC  (mCyc),
        .m_STB  (mStb),
        .m_WE   (mWe),
        .m_DAT_R(mDatR),
        .m_ACK  (mAck),
        .m_ERR  (mErr),
        .s_ADR  (sAdr),
        .s_DAT_W(sDatW),
        .s_SEL  (sSel),
        .s_CYC  (sCyc),
        .s_STB  (sStb),
        .s_WE   (sWe),
        .s_DAT_R(sDatR),
        .s_ACK  (sAck),
        .s_ERR  (sErr),
        .gnt_o  (gnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Hard stop so a wedged run still reports.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] cyc, input logic [3:0] stb,
                                 input logic ack, input logic err);
        rst_i = r;
        mCyc  = cyc;
        mStb  = stb;
        sAck  = ack;
        sErr  = err;
    endtask

    // Expected outputs follow from who owns the bus this cycle.
    task automatic modelCheck();
        logic [3:0] eGnt, eAck, eErr;
        logic       eCyc, eStb;
        bit         inGrant;
        eGnt    = (refOwner >= 0) ? 4'(1 << refOwner) : 4'b0000;
        inGrant = (refOwner >= 0) && !refAbort;
        eCyc = 1'b0;
        eStb = 1'b0;
        eAck = 4'b0000;
        eErr = 4'b0000;
        if (inGrant) begin
            eCyc = mCyc[refOwner];
            eStb = mStb[refOwner];
        end
        if (!rst_i) begin
            if (inGrant && sAck) eAck = eGnt;
            if ((inGrant && sErr) || refAbort) eErr = eGnt;
        end
        checkOutput("gnt_o", gnt, eGnt);
        checkOutput("s_CYC", sCyc, eCyc);
        checkOutput("s_STB", sStb, eStb);
        checkOutput("m_ACK", mAck, eAck);
        checkOutput("m_ERR", mErr, eErr);
        checkOutput("m_DAT_R", mDatR, sDatR);
        if (inGrant) begin
            checkOutput("s_ADR", sAdr, mAdr[refOwner*AW +: AW]);
            checkOutput("s_DAT_W", sDatW, mDatW[refOwner*DW +: DW]);
            checkOutput("s_SEL", sSel, mSel[refOwner*4 +: 4]);
            checkOutput("s_WE", sWe, mWe[refOwner]);
        end
    endtask

    task automatic modelAdvance();
        if (rst_i) begin
            refOwner = -1;
            refAbort = 1'b0;
            refPtr   = 0;
            refWdog  = 0;
        end else if (refAbort) begin
            refPtr   = (refOwner + 1) % N;
            refOwner = -1;
            refAbort = 1'b0;
            refWdog  = 0;
        end else if (refOwner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (refOwner < 0 && mCyc[(refPtr + k) % N]) refOwner = (refPtr + k) % N;
            end
        end else if (!mCyc[refOwner]) begin
            refPtr   = (refOwner + 1) % N;
            refOwner = -1;
            refWdog  = 0;
        end else if (sAck || sErr || !mStb[refOwner]) begin
            refWdog = 0;
        end else if (refWdog == TO) begin
            refAbort = 1'b1;
            refWdog  = 0;
        end else begin
            refWdog++;
        end
    endtask

    task automatic atNegedge();
        @(negedge clk_i);
        modelCheck();
        modelAdvance();
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic runCycle();
        atNegedge();
        nextCycle();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        runCycle();
        runCycle();
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        // cyc (stb follows cyc), ack, err, expGnt, expSCyc, expAck, expErr
        vecs[0]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000};
        vecs[8]  = '{4'b1011, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1011, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000};
        vecs[11] = '{4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
        vecs[14] = '{4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, 4'b0001};
        vecs[15] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
        vecs[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};

        for (int i = 0; i < N; i++) begin
            mAdr[i*AW +: AW]  = 32'h2000_0000 + 32'(i * 16);
            mDatW[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
        end
        mAdr[1*AW +: AW]  = 32'h1000_0004;
        mDatW[1*DW +: DW] = 32'hDEAD_BEEF;
        mSel  = 16'hFFFF;
        mWe   = 4'b0010;
        sDatR = 32'h0;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        nextCycle();

        // Reset state.
        doReset();
        atNegedge();
        checkOutput("reset_gnt", gnt, 4'b0000);
        checkOutput("reset_scyc", sCyc, 1'b0);
        checkOutput("reset_sadr", sAdr, 32'h0);
        checkOutput("reset_ack_err", {mAck, mErr}, 8'h00);
        nextCycle();

        // Vector table: single master write, then rotation with ERR.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, vecs[i].cyc, vecs[i].cyc, vecs[i].ack, vecs[i].err);
            atNegedge();
            checkOutput($sformatf("vec%0d_gnt", i), gnt, vecs[i].expGnt);
            checkOutput($sformatf("vec%0d_scyc", i), sCyc, vecs[i].expSCyc);
            checkOutput($sformatf("vec%0d_ack", i), mAck, vecs[i].expAck);
            checkOutput($sformatf("vec%0d_err", i), mErr, vecs[i].expErr);
            if (i == 3) begin
                checkOutput("write_sadr", sAdr, 32'h1000_0004);
                checkOutput("write_sdat", sDatW, 32'hDEAD_BEEF);
                checkOutput("write_swe", sWe, 1'b1);
            end
            nextCycle();
        end

        // Fairness: every master always requesting, one beat per grant.
        doReset();
        for (int k = 0; k < 8; k++) begin
            logic [3:0] own;
            own = 4'(1 << (k % N));
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
            atNegedge();
            checkOutput("fair_idle_gnt", gnt, 4'b0000);
            nextCycle();
            atNegedge();
            checkOutput($sformatf("fair_grant%0d", k), gnt, own);
            checkOutput($sformatf("fair_ack%0d", k), mAck, own);
            nextCycle();
            applyStimulus(1'b0, 4'b1111 & ~own, 4'b1111 & ~own, 1'b0, 1'b0);
            atNegedge();
            checkOutput("fair_gap_scyc", sCyc, 1'b0);
            nextCycle();
        end

        // Reset in the middle of a stalled m0 write, with a late ACK.
        doReset();
        mWe = 4'b0001;
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) runCycle();
        applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0);
        atNegedge();
        checkOutput("rstmid_ack", mAck, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
        atNegedge();
        checkOutput("rstmid_gnt", gnt, 4'b0000);
        checkOutput("rstmid_bus", {sCyc, sStb, sWe}, 3'b000);
        checkOutput("rstmid_sadr", sAdr, 32'h0);
        checkOutput("rstmid_resp", {mAck, mErr}, 8'h00);
        nextCycle();
        atNegedge();
        checkOutput("rstmid_regrant", gnt, 4'b0001);
        nextCycle();

        // No preemption: m2 bursts four beats while m0 waits.
        doReset();
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0);
        runCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'b0101, 4'b0101, 1'b1, 1'b0);
            atNegedge();
            checkOutput("nopre_gnt", gnt, 4'b0100);
            checkOutput("nopre_ack_m0", mAck[0], 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
        runCycle();
        atNegedge();
        checkOutput("nopre_idle", gnt, 4'b0000);
        nextCycle();
        atNegedge();
        checkOutput("nopre_m0", gnt, 4'b0001);
        nextCycle();

        // Watchdog abort of a silent slave on m3; m0 requests meanwhile.
        doReset();
        applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
        runCycle();
        for (int k = 0; k < 12; k++) begin
            logic [3:0] req;
            req = (k >= 10) ? 4'b0001 : ((k >= 2) ? 4'b1001 : 4'b1000);
            applyStimulus(1'b0, req, req, 1'b0, 1'b0);
            atNegedge();
            if (k <= 8) begin
                checkOutput($sformatf("tmo_noerr%0d", k), mErr, 4'b0000);
                checkOutput($sformatf("tmo_scyc%0d", k), sCyc, 1'b1);
            end else if (k == 9) begin
                checkOutput("tmo_err", mErr, 4'b1000);
                checkOutput("tmo_abort_scyc", sCyc, 1'b0);
                checkOutput("tmo_abort_gnt", gnt, 4'b1000);
            end else if (k == 10) begin
                checkOutput("tmo_idle", gnt, 4'b0000);
                checkOutput("tmo_err_once", mErr, 4'b0000);
            end else begin
                checkOutput("tmo_next_m0", gnt, 4'b0001);
            end
            nextCycle();
        end

        // ACK arriving on the same cycle the watchdog expires.
        doReset();
        applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0);
        runCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 4'b0010, 4'b0010, (k == 8), 1'b0);
            atNegedge();
            if (k == 8) begin
                checkOutput("race_ack", mAck, 4'b0010);
                checkOutput("race_noerr", mErr, 4'b0000);
            end
            if (k == 9) begin
                checkOutput("race_hold_gnt", gnt, 4'b0010);
                checkOutput("race_hold_scyc", sCyc, 1'b1);
                checkOutput("race_hold_noerr", mErr, 4'b0000);
            end
            nextCycle();
        end

        // Randomized traffic against the reference model.
        begin
            logic [3:0] cyc;
            bit         deaf;
            cyc  = 4'b0000;
            deaf = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(5) == 0) cyc[i] = ~cyc[i];
                    mAdr[i*AW +: AW]  = $urandom;
                    mDatW[i*DW +: DW] = $urandom;
                    mSel[i*4 +: 4]    = 4'($urandom);
                end
                if ($urandom_range(39) == 0) deaf = ~deaf;
                mWe   = 4'($urandom);
                sDatR = $urandom;
                applyStimulus(($urandom_range(255) == 0), cyc, cyc & 4'($urandom | $urandom),
                              !deaf && ($urandom_range(2) == 0),
                              !deaf && ($urandom_range(15) == 0));
                runCycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
